// File: rtl/audio_pio_pkg.sv
// Shared definitions for the audio event PIO: register map, edge-type
// encodings and the per-bit edge detector used by input PIOs.
package audio_pio_pkg;

   // Word addresses on the Avalon-MM slave
   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_RSVD    = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   // Edge selection for the capture register
   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;

   localparam int BUS_W = 32;

   // Per-bit edge detection between the current and previous synchronized level.
   function automatic logic [BUS_W-1:0] detect_edges(
      input logic [BUS_W-1:0] sync_now,
      input logic [BUS_W-1:0] sync_prev,
      input int               edge_type
   );
      logic [BUS_W-1:0] w_edges;
      w_edges = '0;
      case (edge_type)
         EDGE_RISING:  w_edges = sync_now & ~sync_prev;
         EDGE_FALLING: w_edges = ~sync_now & sync_prev;
         EDGE_ANY:     w_edges = sync_now ^ sync_prev;
         default:      w_edges = '0;
      endcase
      return w_edges;
   endfunction

endpackage

// File: rtl/pio_input_sync.sv
// WIDTH-bit multi-flop synchronizer for asynchronous input lines.
// Shared by the input PIOs; the chain clears asynchronously on reset.
module pio_input_sync #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] i_async,
   output logic [WIDTH-1:0] o_sync
);

   // Stage 0 is the metastability-catching flop; the last stage is the output.
   logic [STAGES-1:0][WIDTH-1:0] r_chain;

   // Shift the raw lines through the flop chain each clock.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_chain <= '0;
      end else begin
         r_chain <= {r_chain[STAGES-2:0], i_async};
      end
   end

   assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/audio_event_pio.sv
// Avalon-MM input PIO: synchronizes event lines, exposes their level,
// latches selected edges into a write-1-to-clear capture register and
// raises a level interrupt for unmasked captured bits.
module audio_event_pio
   import audio_pio_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int EDGE_TYPE   = EDGE_RISING,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             read_n,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   // Edges are ignored until the synchronizer and prev flop hold real data,
   // so lines held high through reset do not capture on release.
   localparam logic [2:0] WARM_CYCLES = 3'(SYNC_STAGES + 1);

   logic [WIDTH-1:0] w_sync;
   logic [WIDTH-1:0] r_prev;
   logic [WIDTH-1:0] r_edgecap;
   logic [WIDTH-1:0] r_irqmask;
   logic [WIDTH-1:0] w_edge;
   logic [WIDTH-1:0] w_clear;
   logic [31:0]      w_edge_all;
   logic [31:0]      w_rdata;
   logic [31:0]      r_readdata;
   logic [2:0]       r_warm;
   logic             w_warm_done;
   logic             w_wr;
   logic             w_rd;

   pio_input_sync #(
      .WIDTH  (WIDTH),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .i_async (in_port),
      .o_sync  (w_sync)
   );

   assign w_wr        = chipselect & ~write_n;
   assign w_rd        = chipselect & ~read_n;
   assign w_warm_done = (r_warm == WARM_CYCLES);
   assign w_edge_all  = detect_edges(32'(w_sync), 32'(r_prev), EDGE_TYPE);
   assign w_edge      = w_warm_done ? w_edge_all[WIDTH-1:0] : '0;
   assign w_clear     = (w_wr && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;

   // Previous synchronized level for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_prev <= '0;
      end else begin
         r_prev <= w_sync;
      end
   end

   // Warm-up counter: saturates once edge detection may be trusted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_warm <= '0;
      end else if (!w_warm_done) begin
         r_warm <= r_warm + 3'd1;
      end
   end

   // Edge capture: write-1-to-clear, a coincident new edge keeps the bit set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_edgecap <= '0;
      end else begin
         r_edgecap <= (r_edgecap & ~w_clear) | w_edge;
      end
   end

   // Interrupt mask, replaced wholesale by a write to its address.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_irqmask <= '0;
      end else if (w_wr && (address == ADDR_IRQMASK)) begin
         r_irqmask <= writedata[WIDTH-1:0];
      end
   end

   // Read mux over pre-write register values, zero-extended to the bus.
   always_comb begin
      w_rdata = '0;
      case (address)
         ADDR_DATA:    w_rdata[WIDTH-1:0] = w_sync;
         ADDR_IRQMASK: w_rdata[WIDTH-1:0] = r_irqmask;
         ADDR_EDGECAP: w_rdata[WIDTH-1:0] = r_edgecap;
         default:      w_rdata = '0;
      endcase
   end

   // Registered read data; holds its value between reads.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_readdata <= '0;
      end else if (w_rd) begin
         r_readdata <= w_rdata;
      end
   end

   assign readdata = r_readdata;
   assign irq      = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_audio_event_pio.sv
// Bench for audio_event_pio: three instances (rising, falling, any edge)
// share one bus and input; a history-based model predicts readdata and irq.
module tb_audio_event_pio;
   import audio_pio_pkg::*;

   localparam int S      = 2;
   localparam int NT     = 3;
   localparam int HIST_N = 16384;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        read_n = 1'b1;
   logic        write_n = 1'b1;
   logic [31:0] writedata = 32'd0;
   logic [31:0] in_port = 32'd0;
   logic [NT-1:0][31:0] rd_bus;
   logic [NT-1:0]       irq_bus;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   generate
      for (genvar gi = 0; gi < NT; gi++) begin : g_dut
         audio_event_pio #(
            .WIDTH       (32),
            .EDGE_TYPE   (gi),
            .SYNC_STAGES (S)
         ) u_dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .address    (address),
            .chipselect (chipselect),
            .read_n     (read_n),
            .write_n    (write_n),
            .writedata  (writedata),
            .in_port    (in_port),
            .readdata   (rd_bus[gi]),
            .irq        (irq_bus[gi])
         );
      end
   endgenerate

   // ---------------- behavioural model ----------------
   // hist[j] is in_port as sampled at the j-th clock edge since reset release;
   // cyc is the number of edges seen since release.
   logic [31:0] hist [HIST_N];
   int          cyc;
   logic [31:0] m_ec [NT];
   logic [31:0] m_rd [NT];
   logic [31:0] m_mask;

   // Synchronized level after m edges: the input seen S-1 edges earlier.
   function automatic logic [31:0] sync_at(input int m);
      if (m - S + 1 >= 1) return hist[m - S + 1];
      return 32'd0;
   endfunction

   task automatic m_reset();
      cyc    = 0;
      m_mask = 32'd0;
      for (int t = 0; t < NT; t++) begin
         m_ec[t] = 32'd0;
         m_rd[t] = 32'd0;
      end
   endtask

   task automatic m_step();
      logic [31:0] sc, pc, e, clr;
      logic        wr, rd;
      sc  = sync_at(cyc);
      pc  = sync_at(cyc - 1);
      wr  = chipselect && !write_n;
      rd  = chipselect && !read_n;
      clr = (wr && address == 2'd3) ? writedata : 32'd0;
      for (int t = 0; t < NT; t++) begin
         case (t)
            0:       e = sc & ~pc;
            1:       e = ~sc & pc;
            default: e = sc ^ pc;
         endcase
         if (cyc < S + 1) e = 32'd0;
         if (rd) begin
            case (address)
               2'd0:    m_rd[t] = sc;
               2'd2:    m_rd[t] = m_mask;
               2'd3:    m_rd[t] = m_ec[t];
               default: m_rd[t] = 32'd0;
            endcase
         end
         m_ec[t] = (m_ec[t] & ~clr) | e;
      end
      if (wr && address == 2'd2) m_mask = writedata;
      if (cyc < HIST_N - 1) begin
         cyc       = cyc + 1;
         hist[cyc] = in_port;
      end
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) m_reset();
         else          m_step();
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison of all instances against the model.
   initial begin
      forever begin
         @(negedge clk);
         for (int t = 0; t < NT; t++) begin
            chk($sformatf("model_rdata[%0d]", t), rd_bus[t], m_rd[t]);
            chk($sformatf("model_irq[%0d]", t), {31'd0, irq_bus[t]},
                {31'd0, |(m_ec[t] & m_mask)});
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      chipselect = 1'b0;
      read_n     = 1'b1;
      write_n    = 1'b1;
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      tick();
      bus_idle();
   endtask

   task automatic bus_rd(input logic [1:0] a);
      address = a; chipselect = 1'b1; read_n = 1'b0;
      tick();
      bus_idle();
   endtask

   task automatic do_reset();
      #2 reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      reset_n = 1'b1;
      in_port = 32'hFFFF_FFFF;
      #1 reset_n = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;

      // Lines held high through reset: no capture, no irq
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("hold_hi_irq", {29'd0, irq_bus}, 32'd0);
      end
      bus_rd(2'd3);
      for (int t = 0; t < NT; t++) chk("hold_hi_edgecap", rd_bus[t], 32'd0);

      // Rising edge to irq timing on the rising instance
      in_port = 32'd0;
      repeat (6) tick();
      bus_wr(2'd3, 32'hFFFF_FFFF);
      bus_wr(2'd2, 32'h1);
      in_port = 32'h1;
      tick();
      tick();
      chk("rise_irq_early", {31'd0, irq_bus[0]}, 32'd0);
      tick();
      chk("rise_irq_k2", {31'd0, irq_bus[0]}, 32'd1);
      bus_rd(2'd3);
      chk("rise_ec_bit0", rd_bus[0], 32'h1);
      in_port = 32'h3;
      repeat (4) tick();
      bus_rd(2'd3);
      chk("rise_ec_bit1", rd_bus[0], 32'h3);
      chk("rise_irq_stays", {31'd0, irq_bus[0]}, 32'd1);
      bus_wr(2'd3, 32'h1);
      chk("w1c_irq_drop", {31'd0, irq_bus[0]}, 32'd0);
      bus_rd(2'd3);
      chk("w1c_ec", rd_bus[0], 32'h2);

      // W1C collides with a newly detected edge on the same bit
      in_port = 32'h2;
      repeat (4) tick();
      in_port = 32'h3;
      tick();
      tick();
      chk("coll_irq_before", {31'd0, irq_bus[0]}, 32'd0);
      bus_wr(2'd3, 32'h1);
      chk("coll_irq", {31'd0, irq_bus[0]}, 32'd1);
      bus_rd(2'd3);
      chk("coll_ec", rd_bus[0], 32'h3);

      // Data path, edge types and read latency
      in_port = 32'd0;
      repeat (5) tick();
      bus_wr(2'd3, 32'hFFFF_FFFF);
      in_port = 32'hA5;
      repeat (5) tick();
      in_port = 32'h5A;
      repeat (5) tick();
      bus_rd(2'd3);
      chk("any_ec", rd_bus[2], 32'hFF);
      chk("rise_ec", rd_bus[0], 32'hFF);
      chk("fall_ec", rd_bus[1], 32'hA5);
      bus_rd(2'd0);
      chk("data_read", rd_bus[2], 32'h5A);
      bus_rd(2'd1);
      chk("rsvd_read", rd_bus[2], 32'd0);
      address = 2'd0; chipselect = 1'b1; read_n = 1'b0;
      #1;
      chk("lat_before_edge", rd_bus[2], 32'd0);
      tick();
      bus_idle();
      chk("lat_after_edge", rd_bus[2], 32'h5A);

      // Read and write of the same register in one cycle
      address = 2'd2; writedata = 32'hF0; chipselect = 1'b1; read_n = 1'b0; write_n = 1'b0;
      tick();
      bus_idle();
      chk("rw_prewrite", rd_bus[0], 32'h1);
      bus_rd(2'd2);
      chk("rw_postwrite", rd_bus[0], 32'hF0);

      // Reset in the middle of operation
      bus_wr(2'd2, 32'hF);
      in_port = 32'd0;
      repeat (5) tick();
      bus_wr(2'd3, 32'hFFFF_FFFF);
      in_port = 32'h3;
      repeat (5) tick();
      bus_rd(2'd3);
      chk("mid_ec", rd_bus[0], 32'h3);
      chk("mid_irq", {31'd0, irq_bus[0]}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_irq", {29'd0, irq_bus}, 32'd0);
      for (int t = 0; t < NT; t++) chk("rst_rdata", rd_bus[t], 32'd0);
      tick();
      tick();
      reset_n = 1'b1;
      repeat (6) tick();
      bus_rd(2'd2);
      chk("rst_mask", rd_bus[0], 32'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 1) == 0) in_port = in_port ^ ($urandom & $urandom & $urandom);
         chipselect = ($urandom_range(0, 5) != 0);
         read_n     = $urandom_range(0, 2) != 0;
         write_n    = $urandom_range(0, 2) != 0;
         address    = 2'($urandom_range(0, 3));
         writedata  = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom & $urandom);
         if ($urandom_range(0, 399) == 0) begin
            bus_idle();
            do_reset();
         end else begin
            tick();
         end
      end
      bus_idle();
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
